// File: rtl/pipe_adder_pkg.sv
// Shared defaults, slice-width macro and parameter helpers for pipe_adder.
// Included first so ADDER_WIDTH / ADDER_STAGES / ADDER_CW are visible to later files.
`ifndef ADDER_DEFS_VH
`define ADDER_DEFS_VH
`define ADDER_WIDTH 32
`define ADDER_STAGES 4
`define ADDER_CW(w, s) ((w) / (s))
`endif

package pipe_adder_pkg;

   localparam int DEF_WIDTH  = `ADDER_WIDTH;
   localparam int DEF_STAGES = `ADDER_STAGES;

   function automatic int slice_width(input int w, input int s);
      return (s > 0) ? `ADDER_CW(w, s) : w;
   endfunction

   // Legal when every stage gets an equal, non-empty slice.
   function automatic bit width_ok(input int w, input int s);
      return (s >= 1) && (s <= w) && ((w % s) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// CW-bit combinational ripple slice: {co, s} = a + b + ci.
module pipe_adder_slice
   import pipe_adder_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          ci_i,
   output logic [CW-1:0] s_o,
   output logic          co_o
);

   always_comb begin
      {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, ci_i};
   end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one CW-bit slice per stage, valid/ready on both sides.
// Optional subtract mode (port sub) is enabled by defining PIPE_ADDER_SUB_EN.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = slice_width(WIDTH, STAGES);

   if (!width_ok(WIDTH, STAGES)) begin : g_param_check
      $error("pipe_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
   end

   logic             stall;
   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

`ifdef PIPE_ADDER_SUB_EN
   // Subtraction folds into the add: a + ~b + 1, so only stage 0 needs to know about it.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? 1'b1 : cin;
`else
   assign b_eff = b;
   assign c0    = cin;
`endif

   // All stages move or hold together; bubbles are not squeezed out.
   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = advance;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int DONE = (gi + 1) * CW;
         localparam int REM  = WIDTH - DONE;

         logic [CW-1:0]   sa;
         logic [CW-1:0]   sb;
         logic [CW-1:0]   s;
         logic            ci;
         logic            co;
         logic            valid_d;
         logic            valid_q;
         logic [DONE-1:0] sum_d;
         logic [DONE-1:0] sum_q;
         logic            carry_q;

         if (gi == 0) begin : g_head
            assign sa      = a[CW-1:0];
            assign sb      = b_eff[CW-1:0];
            assign ci      = c0;
            assign valid_d = in_valid;
            assign sum_d   = s;
         end else begin : g_body
            assign sa      = g_stage[gi-1].g_rem.a_rem_q[CW-1:0];
            assign sb      = g_stage[gi-1].g_rem.b_rem_q[CW-1:0];
            assign ci      = g_stage[gi-1].carry_q;
            assign valid_d = g_stage[gi-1].valid_q;
            assign sum_d   = {s, g_stage[gi-1].sum_q};
         end

         pipe_adder_slice #(
            .CW (CW)
         ) u_slice (
            .a_i  (sa),
            .b_i  (sb),
            .ci_i (ci),
            .s_o  (s),
            .co_o (co)
         );

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_q <= 1'b0;
               sum_q   <= '0;
               carry_q <= 1'b0;
            end else if (advance) begin
               valid_q <= valid_d;
               sum_q   <= sum_d;
               carry_q <= co;
            end
         end

         // Unprocessed upper operand bits, shifted so the next slice always sits at bit 0.
         if (REM > 0) begin : g_rem
            logic [REM-1:0] a_rem_d;
            logic [REM-1:0] b_rem_d;
            logic [REM-1:0] a_rem_q;
            logic [REM-1:0] b_rem_q;

            if (gi == 0) begin : g_from_in
               assign a_rem_d = a[WIDTH-1:CW];
               assign b_rem_d = b_eff[WIDTH-1:CW];
            end else begin : g_from_prev
               assign a_rem_d = g_stage[gi-1].g_rem.a_rem_q[REM+CW-1:CW];
               assign b_rem_d = g_stage[gi-1].g_rem.b_rem_q[REM+CW-1:CW];
            end

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  a_rem_q <= '0;
                  b_rem_q <= '0;
               end else if (advance) begin
                  a_rem_q <= a_rem_d;
                  b_rem_q <= b_rem_d;
               end
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign sum       = g_stage[STAGES-1].sum_q;
   assign cout      = g_stage[STAGES-1].carry_q;

endmodule
